muldiv_unit: RTL and testbench

Multi-cycle integer multiply/divide unit with architectural HI/LO registers, parametrised in operand width and bits retired per cycle. It sits beside the ALU in the MIPS datapath. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and exposes HI/LO for MFHI/MFLO result selection. Iterative shift-add multiply and restoring divide replace single-cycle combinational mult/div; `busy` drives the pipeline stall.

---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_unit_step.sv | 23 ++
 rtl/muldiv_unit.sv | 120 ++++++++++++
 tb/tb_muldiv_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, FSM states and sign helper for the multiply/divide unit
package muldiv_pkg;
   localparam int MAX_W = 64;
   localparam int XW = 2 * MAX_W;
   typedef enum logic [2:0] {
      MULT  = 3'd0,
      MULTU = 3'd1,
      DIV   = 3'd2,
      DIVU  = 3'd3,
      MTHI  = 3'd4,
      MTLO  = 3'd5
   } muldiv_op_t;
   typedef enum logic [1:0] {IDLE, RUN, FIN} muldiv_state_t;
   // two's-complement negate when n is set; callers size-cast to their own width
   function automatic logic [XW-1:0] cond_neg(input logic [XW-1:0] v, input logic n);
      return n ? -v : v;
   endfunction
endpackage

// File: rtl/muldiv_unit_step.sv
// muldiv_unit_step: one shift-add (multiply) or restore-subtract (divide) iteration
module muldiv_unit_step #(
   parameter int WIDTH = 32
) (
   input  logic             i_div,
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_q,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_rem,
   output logic [WIDTH-1:0] o_q
);
   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_sh;
   logic [WIDTH:0] w_diff;
   // remainder stays below the divisor, so a WIDTH+1-bit difference holds the sign safely
   always_comb begin
      w_sum  = {1'b0, i_rem} + {1'b0, (i_q[0] ? i_d : {WIDTH{1'b0}})};
      w_sh   = {i_rem, i_q[WIDTH-1]};
      w_diff = w_sh - {1'b0, i_d};
      o_rem  = i_div ? (w_diff[WIDTH] ? w_sh[WIDTH-1:0] : w_diff[WIDTH-1:0]) : w_sum[WIDTH:1];
      o_q    = i_div ? {i_q[WIDTH-2:0], ~w_diff[WIDTH]} : {w_sum[0], i_q[WIDTH-1:1]};
   end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS multiply/divide with architectural HI/LO registers
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int UNROLL = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clk_enable,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int N  = WIDTH / UNROLL;
   localparam int CW = $clog2(N + 1);
   localparam int PW = 2 * WIDTH;

   muldiv_state_t    r_state, w_next;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_rem, r_q, r_d, r_hi, r_lo;
   logic             r_div, r_neg_q, r_neg_r, r_dbz, r_done;
   logic             w_go, w_div, w_sgn, w_a_neg, w_b_neg;
   logic [WIDTH-1:0] w_a_abs, w_b_abs, w_quo, w_rmd;
   logic [PW-1:0]    w_prod;
   logic [WIDTH-1:0] w_rem [0:UNROLL];
   logic [WIDTH-1:0] w_q   [0:UNROLL];

   assign w_go    = (r_state == IDLE) && start && (op == MULT || op == MULTU || op == DIV || op == DIVU);
   assign w_div   = (op == DIV) || (op == DIVU);
   assign w_sgn   = (op == MULT) || (op == DIV);
   assign w_a_neg = w_sgn & a[WIDTH-1];
   assign w_b_neg = w_sgn & b[WIDTH-1];

   // operand magnitudes on entry, sign fix-up of the finished result on exit
   always_comb begin
      w_a_abs = WIDTH'(cond_neg(XW'(a), w_a_neg));
      w_b_abs = WIDTH'(cond_neg(XW'(b), w_b_neg));
      w_prod  = PW'(cond_neg(XW'({r_rem, r_q}), r_neg_q));
      w_quo   = WIDTH'(cond_neg(XW'(r_q), r_neg_q));
      w_rmd   = WIDTH'(cond_neg(XW'(r_rem), r_neg_r));
   end

   assign w_rem[0] = r_rem;
   assign w_q[0]   = r_q;
   for (genvar i = 0; i < UNROLL; i++) begin : g_step
      muldiv_unit_step #(.WIDTH(WIDTH)) u_step (
         .i_div (r_div),
         .i_rem (w_rem[i]),
         .i_q   (w_q[i]),
         .i_d   (r_d),
         .o_rem (w_rem[i+1]),
         .o_q   (w_q[i+1])
      );
   end

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else if (clk_enable) r_state <= w_next;
   end

   // next state: accept in IDLE, count down in RUN, one commit cycle in FIN
   always_comb begin
      w_next = (r_state == IDLE && w_go) ? RUN :
               (r_state == RUN && r_cnt == CW'(1)) ? FIN :
               (r_state == FIN) ? IDLE : r_state;
   end

   // datapath: operand latch, iteration, HI/LO moves and atomic result commit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt   <= '0;
         r_rem   <= '0;
         r_q     <= '0;
         r_d     <= '0;
         r_div   <= 1'b0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_dbz   <= 1'b0;
         r_done  <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else if (clk_enable) begin
         r_done <= (r_state == FIN);
         if (w_go) begin
            r_cnt   <= CW'(N);
            r_rem   <= '0;
            r_q     <= w_div ? w_a_abs : w_b_abs;
            r_d     <= w_div ? w_b_abs : w_a_abs;
            r_div   <= w_div;
            r_neg_q <= (w_a_neg ^ w_b_neg) & (|b);
            r_neg_r <= w_a_neg;
            r_dbz   <= w_div & ~(|b);
         end else if (r_state == RUN) begin
            r_cnt <= r_cnt - CW'(1);
            r_rem <= w_rem[UNROLL];
            r_q   <= w_q[UNROLL];
         end
         if (r_state == IDLE && start && op == MTHI) r_hi <= a;
         if (r_state == IDLE && start && op == MTLO) r_lo <= a;
         if (r_state == FIN) begin
            r_hi <= r_div ? w_rmd : w_prod[PW-1:WIDTH];
            r_lo <= r_div ? w_quo : w_prod[WIDTH-1:0];
         end
      end
   end

   assign busy        = (r_state != IDLE);
   assign done        = r_done;
   assign div_by_zero = r_done & r_dbz;
   assign hi          = r_hi;
   assign lo          = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clk_enable = 1'b1;
   logic        start = 1'b0;
   logic        start4 = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy, done, dbz, busy4, done4, dbz4;
   logic [31:0] hi, lo, hi4, lo4;
   int          n_tests = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(32), .UNROLL(1)) dut (
      .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start), .op(op),
      .a(a), .b(b), .busy(busy), .done(done), .div_by_zero(dbz), .hi(hi), .lo(lo)
   );

   muldiv_unit #(.WIDTH(32), .UNROLL(4)) dut4 (
      .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start4), .op(op),
      .a(a), .b(b), .busy(busy4), .done(done4), .div_by_zero(dbz4), .hi(hi4), .lo(lo4)
   );

   task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit now, output int lat, output int bc);
      if (!now) @(negedge clk);
      op = o; a = x; b = y; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0; bc = 0;
      while (!done && lat < 200) begin
         if (busy) bc++;
         @(negedge clk);
         lat++;
      end
      if (!done) lat = -1;
   endtask

   task automatic test_reset;
      @(negedge clk);
      n_tests++;
      if ({busy, done, dbz} !== 3'b000) begin
         n_fail++; $display("FAIL reset_flags: got %b want 000", {busy, done, dbz});
      end
      n_tests++;
      if ({hi, lo} !== 64'h0) begin
         n_fail++; $display("FAIL reset_hilo: got %h want 0", {hi, lo});
      end
      reset = 1'b0;
   endtask

   task automatic test_multu;
      int lat, bc;
      run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, bc);
      n_tests++;
      if (lat !== 33) begin n_fail++; $display("FAIL multu_latency: got %0d want 33", lat); end
      n_tests++;
      if (bc !== 33) begin n_fail++; $display("FAIL multu_busy: got %0d want 33", bc); end
      n_tests++;
      if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin
         n_fail++; $display("FAIL multu_result: got %h want fffffffe00000001", {hi, lo});
      end
      n_tests++;
      if (dbz !== 1'b0) begin n_fail++; $display("FAIL multu_dbz: got %b want 0", dbz); end
   endtask

   task automatic test_mult_signed;
      int lat, bc;
      run_op(MULT, 32'hFFFFFFFD, 32'd7, 1'b0, lat, bc);
      n_tests++;
      if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin
         n_fail++; $display("FAIL mult_signed: got %h want ffffffffffffffeb", {hi, lo});
      end
   endtask

   task automatic test_back_to_back;
      int lat, bc;
      run_op(DIV, 32'hFFFFFFF9, 32'd2, 1'b0, lat, bc);
      n_tests++;
      if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin
         n_fail++; $display("FAIL div_signed: got %h want fffffffffffffffd", {hi, lo});
      end
      run_op(DIVU, 32'd7, 32'd2, 1'b1, lat, bc);
      n_tests++;
      if (lat !== 33) begin n_fail++; $display("FAIL b2b_latency: got %0d want 33", lat); end
      n_tests++;
      if ({hi, lo} !== {32'd1, 32'd3}) begin
         n_fail++; $display("FAIL divu_b2b: got %h want 0000000100000003", {hi, lo});
      end
   endtask

   task automatic test_div_zero;
      int lat, bc;
      run_op(DIVU, 32'd5, 32'd0, 1'b0, lat, bc);
      n_tests++;
      if ({dbz, hi, lo} !== {1'b1, 32'd5, 32'hFFFFFFFF}) begin
         n_fail++; $display("FAIL divu_zero: got dbz=%b %h_%h want dbz=1 00000005_ffffffff", dbz, hi, lo);
      end
      @(negedge clk);
      n_tests++;
      if ({done, dbz} !== 2'b00) begin
         n_fail++; $display("FAIL dbz_pulse: got %b want 00", {done, dbz});
      end
      run_op(DIV, 32'hFFFFFFF9, 32'd0, 1'b0, lat, bc);
      n_tests++;
      if ({dbz, hi, lo} !== {1'b1, 32'hFFFFFFF9, 32'hFFFFFFFF}) begin
         n_fail++; $display("FAIL div_zero_neg: got dbz=%b %h_%h want dbz=1 fffffff9_ffffffff", dbz, hi, lo);
      end
   endtask

   task automatic test_div_overflow;
      int lat, bc;
      run_op(DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, lat, bc);
      n_tests++;
      if ({dbz, hi, lo} !== {1'b0, 32'd0, 32'h80000000}) begin
         n_fail++; $display("FAIL div_overflow: got dbz=%b %h_%h want dbz=0 00000000_80000000", dbz, hi, lo);
      end
   endtask

   task automatic test_moves;
      @(negedge clk);
      op = MTLO; a = 32'h1234; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_tests++;
      if ({done, busy, lo} !== {2'b00, 32'h1234}) begin
         n_fail++; $display("FAIL mtlo: got done=%b busy=%b lo=%h want 0 0 00001234", done, busy, lo);
      end
      op = MTHI; a = 32'hCAFE; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_tests++;
      if ({done, hi, lo} !== {1'b0, 32'hCAFE, 32'h1234}) begin
         n_fail++; $display("FAIL mthi: got done=%b %h_%h want 0 0000cafe_00001234", done, hi, lo);
      end
   endtask

   task automatic test_busy_ignore;
      int lat;
      @(negedge clk);
      op = MULT; a = 32'd3; b = 32'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({hi, lo} !== {32'hCAFE, 32'h1234}) begin
         n_fail++; $display("FAIL run_hold: got %h want 0000cafe00001234", {hi, lo});
      end
      op = MTHI; a = 32'hDEAD; start = 1'b1;
      @(negedge clk);
      op = MULTU; a = 32'd9; b = 32'd9;
      @(negedge clk);
      start = 1'b0;
      lat = 5;
      while (!done && lat < 200) begin @(negedge clk); lat++; end
      n_tests++;
      if (lat !== 33) begin n_fail++; $display("FAIL ignore_latency: got %0d want 33", lat); end
      n_tests++;
      if ({hi, lo} !== {32'd0, 32'd15}) begin
         n_fail++; $display("FAIL ignore_result: got %h want 000000000000000f", {hi, lo});
      end
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_idle: got busy=%b want 0", busy); end
   endtask

   task automatic test_clk_enable;
      int lat;
      @(negedge clk);
      op = MULTU; a = 32'd6; b = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 200) begin
         if (lat == 5) clk_enable = 1'b0;
         if (lat == 10) clk_enable = 1'b1;
         @(negedge clk);
         lat++;
      end
      n_tests++;
      if (lat !== 38) begin n_fail++; $display("FAIL ce_latency: got %0d want 38", lat); end
      n_tests++;
      if ({hi, lo} !== {32'd0, 32'd42}) begin
         n_fail++; $display("FAIL ce_result: got %h want 000000000000002a", {hi, lo});
      end
      clk_enable = 1'b0;
      @(negedge clk);
      n_tests++;
      if (done !== 1'b1) begin n_fail++; $display("FAIL ce_done_hold: got %b want 1", done); end
      clk_enable = 1'b1;
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL ce_done_clear: got %b want 0", done); end
   endtask

   task automatic test_reset_mid;
      int seen;
      @(negedge clk);
      op = DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      n_tests++;
      if ({busy, done, dbz, hi, lo} !== 67'h0) begin
         n_fail++; $display("FAIL reset_async: got busy=%b done=%b dbz=%b %h_%h want all 0", busy, done, dbz, hi, lo);
      end
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      repeat (40) begin @(negedge clk); if (done || busy) seen++; end
      n_tests++;
      if (seen !== 0) begin n_fail++; $display("FAIL reset_discard: got %0d active cycles want 0", seen); end
   endtask

   task automatic test_unroll4;
      int lat, bc;
      @(negedge clk);
      op = MULTU; a = 32'd6; b = 32'd7; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      lat = 0; bc = 0;
      while (!done4 && lat < 200) begin
         if (busy4) bc++;
         @(negedge clk);
         lat++;
      end
      n_tests++;
      if (lat !== 9) begin n_fail++; $display("FAIL u4_latency: got %0d want 9", lat); end
      n_tests++;
      if (bc !== 9) begin n_fail++; $display("FAIL u4_busy: got %0d want 9", bc); end
      n_tests++;
      if ({hi4, lo4} !== {32'd0, 32'd42}) begin
         n_fail++; $display("FAIL u4_result: got %h want 000000000000002a", {hi4, lo4});
      end
   endtask

   initial begin
      test_reset();
      test_multu();
      test_mult_signed();
      test_back_to_back();
      test_div_zero();
      test_div_overflow();
      test_moves();
      test_busy_ignore();
      test_clk_enable();
      test_reset_mid();
      test_unroll4();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
